// File: rtl/qdr_arb_pkg.sv
// Shared definitions for the QDR II+ user-interface arbiter.
package qdr_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 19;
    localparam int unsigned DATA_W_DEF = 144;
    localparam int unsigned BW_W_DEF   = 16;
    localparam int unsigned BURST_LEN  = 4;

    // Requester identifier carried through the read tag FIFO.
    typedef logic req_id_t;

    // Byte-write mask with every byte disabled (active low).
    localparam logic [BW_W_DEF-1:0] BW_ALL_OFF = {BW_W_DEF{1'b1}};

endpackage

// File: rtl/qdr_rr_arb2.sv
// Two-way round-robin arbiter; priority moves only after a contested grant.
module qdr_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant
);

    logic prio_q;

    // Combinational grant from request vector and current priority holder.
    always_comb begin
        grant = 2'b00;
        if (enable) begin
            unique case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio_q ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // Priority register: hand priority to the loser of a contested grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (enable && (valid == 2'b11)) begin
            prio_q <= ~prio_q;
        end
    end

endmodule

// File: rtl/qdr_ui_arbiter.sv
// Arbitrates two clients onto the QDR II+ controller user interface and
// routes read returns back to the issuing client via an in-order tag FIFO.
module qdr_ui_arbiter
    import qdr_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = ADDR_W_DEF,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned BW_W      = BW_W_DEF,
    parameter int unsigned TAG_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          init_calib_complete,
    input  logic [1:0]                    wr_valid,
    input  logic [2*ADDR_W-1:0]           wr_addr,
    input  logic [2*DATA_W-1:0]           wr_data,
    input  logic [2*BW_W-1:0]             wr_bw_n,
    output logic [1:0]                    wr_ready,
    input  logic [1:0]                    rd_valid,
    input  logic [2*ADDR_W-1:0]           rd_addr,
    output logic [1:0]                    rd_ready,
    output logic [1:0]                    rsp_valid,
    output logic [DATA_W-1:0]             rsp_data,
    output logic                          app_wr_cmd,
    output logic [ADDR_W-1:0]             app_wr_addr,
    output logic [DATA_W-1:0]             app_wr_data,
    output logic [BW_W-1:0]               app_wr_bw_n,
    output logic                          app_rd_cmd,
    output logic [ADDR_W-1:0]             app_rd_addr,
    input  logic                          app_rd_valid,
    input  logic [DATA_W-1:0]             app_rd_data,
    output logic [$clog2(TAG_DEPTH):0]    rd_outstanding,
    output logic                          err_orphan
);

    localparam int unsigned PW = $clog2(TAG_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(TAG_DEPTH);

    logic [1:0]    wr_grant;
    logic [1:0]    rd_grant;
    logic          rd_enable;
    logic          push;
    logic          pop;
    logic          orphan;
    req_id_t       tag_mem [TAG_DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Reads stall once every tag slot is in use (registered count only).
    assign rd_enable = init_calib_complete && (count_q != FULL_CNT);

    qdr_rr_arb2 u_wr_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  (wr_valid),
        .enable (init_calib_complete),
        .grant  (wr_grant)
    );

    qdr_rr_arb2 u_rd_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  (rd_valid),
        .enable (rd_enable),
        .grant  (rd_grant)
    );

    assign wr_ready       = wr_grant;
    assign rd_ready       = rd_grant;
    assign push           = |rd_grant;
    assign pop            = app_rd_valid && (count_q != '0);
    assign orphan         = app_rd_valid && (count_q == '0);
    assign rd_outstanding = count_q;

    // Register the granted write onto the controller write port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            app_wr_cmd  <= 1'b0;
            app_wr_addr <= '0;
            app_wr_data <= '0;
            app_wr_bw_n <= '1;
        end else begin
            app_wr_cmd <= |wr_grant;
            if (wr_grant[1]) begin
                app_wr_addr <= wr_addr[ADDR_W +: ADDR_W];
                app_wr_data <= wr_data[DATA_W +: DATA_W];
                app_wr_bw_n <= wr_bw_n[BW_W +: BW_W];
            end else if (wr_grant[0]) begin
                app_wr_addr <= wr_addr[0 +: ADDR_W];
                app_wr_data <= wr_data[0 +: DATA_W];
                app_wr_bw_n <= wr_bw_n[0 +: BW_W];
            end
        end
    end

    // Register the granted read onto the controller read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            app_rd_cmd  <= 1'b0;
            app_rd_addr <= '0;
        end else begin
            app_rd_cmd <= push;
            if (rd_grant[1]) begin
                app_rd_addr <= rd_addr[ADDR_W +: ADDR_W];
            end else if (rd_grant[0]) begin
                app_rd_addr <= rd_addr[0 +: ADDR_W];
            end
        end
    end

    // Tag storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= req_id_t'(rd_grant[1]);
        end
    end

    // Tag FIFO pointers and occupancy; reset flushes anything in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            unique case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Route returning data to its requester; flag data with no tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= 2'b00;
            rsp_data   <= '0;
            err_orphan <= 1'b0;
        end else begin
            rsp_valid <= 2'b00;
            if (pop) begin
                rsp_valid <= tag_mem[rd_ptr_q] ? 2'b10 : 2'b01;
                rsp_data  <= app_rd_data;
            end
            if (orphan) begin
                err_orphan <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qdr_ui_arbiter.sv
// Directed bench for qdr_ui_arbiter; inputs change and outputs are sampled
// around the falling edge, away from the active rising edge.
module tb_qdr_ui_arbiter;

    localparam int unsigned ADDR_W = 19;
    localparam int unsigned DATA_W = 144;
    localparam int unsigned BW_W   = 16;
    localparam int unsigned TAG_DEPTH = 16;

    logic                clk = 1'b0;
    logic                rst;
    logic                init_calib_complete;
    logic [1:0]          wr_valid;
    logic [2*ADDR_W-1:0] wr_addr;
    logic [2*DATA_W-1:0] wr_data;
    logic [2*BW_W-1:0]   wr_bw_n;
    logic [1:0]          wr_ready;
    logic [1:0]          rd_valid;
    logic [2*ADDR_W-1:0] rd_addr;
    logic [1:0]          rd_ready;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_data;
    logic                app_wr_cmd;
    logic [ADDR_W-1:0]   app_wr_addr;
    logic [DATA_W-1:0]   app_wr_data;
    logic [BW_W-1:0]     app_wr_bw_n;
    logic                app_rd_cmd;
    logic [ADDR_W-1:0]   app_rd_addr;
    logic                app_rd_valid;
    logic [DATA_W-1:0]   app_rd_data;
    logic [4:0]          rd_outstanding;
    logic                err_orphan;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [ADDR_W-1:0] A0 = 19'h00100;
    localparam logic [ADDR_W-1:0] A1 = 19'h00200;
    localparam logic [DATA_W-1:0] W0 = 144'h1111_2222_3333;
    localparam logic [DATA_W-1:0] W1 = 144'hAAAA_BBBB_CCCC;
    localparam logic [DATA_W-1:0] D1 = 144'hD1D1_0000_0001;
    localparam logic [DATA_W-1:0] D2 = 144'hD2D2_0000_0002;
    localparam logic [DATA_W-1:0] D3 = 144'hD3D3_0000_0003;

    always #5 clk = ~clk;

    qdr_ui_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BW_W      (BW_W),
        .TAG_DEPTH (TAG_DEPTH)
    ) u_dut (
        .clk                 (clk),
        .rst                 (rst),
        .init_calib_complete (init_calib_complete),
        .wr_valid            (wr_valid),
        .wr_addr             (wr_addr),
        .wr_data             (wr_data),
        .wr_bw_n             (wr_bw_n),
        .wr_ready            (wr_ready),
        .rd_valid            (rd_valid),
        .rd_addr             (rd_addr),
        .rd_ready            (rd_ready),
        .rsp_valid           (rsp_valid),
        .rsp_data            (rsp_data),
        .app_wr_cmd          (app_wr_cmd),
        .app_wr_addr         (app_wr_addr),
        .app_wr_data         (app_wr_data),
        .app_wr_bw_n         (app_wr_bw_n),
        .app_rd_cmd          (app_rd_cmd),
        .app_rd_addr         (app_rd_addr),
        .app_rd_valid        (app_rd_valid),
        .app_rd_data         (app_rd_data),
        .rd_outstanding      (rd_outstanding),
        .err_orphan          (err_orphan)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " app_wr_cmd"}, 256'(app_wr_cmd), 256'(0));
        chk({tag, " app_rd_cmd"}, 256'(app_rd_cmd), 256'(0));
        chk({tag, " app_wr_addr"}, 256'(app_wr_addr), 256'(0));
        chk({tag, " app_wr_data"}, 256'(app_wr_data), 256'(0));
        chk({tag, " app_rd_addr"}, 256'(app_rd_addr), 256'(0));
        chk({tag, " app_wr_bw_n"}, 256'(app_wr_bw_n), 256'(16'hFFFF));
        chk({tag, " rsp_valid"}, 256'(rsp_valid), 256'(0));
        chk({tag, " rsp_data"}, 256'(rsp_data), 256'(0));
        chk({tag, " rd_outstanding"}, 256'(rd_outstanding), 256'(0));
        chk({tag, " err_orphan"}, 256'(err_orphan), 256'(0));
    endtask

    initial begin
        rst = 1'b1;
        init_calib_complete = 1'b0;
        wr_valid = 2'b00;
        wr_addr = {A1, A0};
        wr_data = {W1, W0};
        wr_bw_n = {16'h00F0, 16'h0F00};
        rd_valid = 2'b00;
        rd_addr = '0;
        app_rd_valid = 1'b0;
        app_rd_data = '0;

        repeat (3) @(negedge clk);
        chk_reset_vals("reset");
        rst = 1'b0;

        // Calibration gate: no grants while calibration is pending.
        wr_valid = 2'b11;
        #1;
        chk("gate wr_ready", 256'(wr_ready), 256'(2'b00));
        @(negedge clk);
        chk("gate app_wr_cmd", 256'(app_wr_cmd), 256'(0));
        init_calib_complete = 1'b1;

        // Contested writes alternate 0,1,0,1,0,1 starting with requester 0.
        for (int k = 0; k < 6; k++) begin
            #1;
            chk($sformatf("wr grant %0d", k), 256'(wr_ready),
                256'((k % 2 == 0) ? 2'b01 : 2'b10));
            @(negedge clk);
            chk($sformatf("wr cmd %0d", k), 256'(app_wr_cmd), 256'(1));
            chk($sformatf("wr addr %0d", k), 256'(app_wr_addr),
                256'((k % 2 == 0) ? A0 : A1));
            if (k == 1) begin
                chk("wr data req1", 256'(app_wr_data), 256'(W1));
                chk("wr bw req1", 256'(app_wr_bw_n), 256'(16'h00F0));
            end
        end
        wr_valid = 2'b00;
        @(negedge clk);
        chk("wr idle cmd", 256'(app_wr_cmd), 256'(0));

        // Read routing: requester 1 then requester 0.
        rd_valid = 2'b10;
        rd_addr = {19'h00010, 19'h00000};
        #1;
        chk("rd1 ready", 256'(rd_ready), 256'(2'b10));
        @(negedge clk);
        chk("rd1 cmd", 256'(app_rd_cmd), 256'(1));
        chk("rd1 addr", 256'(app_rd_addr), 256'(19'h00010));
        chk("rd1 outst", 256'(rd_outstanding), 256'(1));
        rd_valid = 2'b01;
        rd_addr = {19'h00000, 19'h00020};
        #1;
        chk("rd0 ready", 256'(rd_ready), 256'(2'b01));
        @(negedge clk);
        chk("rd0 addr", 256'(app_rd_addr), 256'(19'h00020));
        chk("rd0 outst", 256'(rd_outstanding), 256'(2));
        rd_valid = 2'b00;
        app_rd_valid = 1'b1;
        app_rd_data = D1;
        @(negedge clk);
        chk("ret1 rsp_valid", 256'(rsp_valid), 256'(2'b10));
        chk("ret1 rsp_data", 256'(rsp_data), 256'(D1));
        chk("ret1 outst", 256'(rd_outstanding), 256'(1));
        app_rd_data = D2;
        @(negedge clk);
        chk("ret2 rsp_valid", 256'(rsp_valid), 256'(2'b01));
        chk("ret2 rsp_data", 256'(rsp_data), 256'(D2));
        chk("ret2 outst", 256'(rd_outstanding), 256'(0));
        app_rd_valid = 1'b0;
        @(negedge clk);
        chk("ret idle rsp_valid", 256'(rsp_valid), 256'(2'b00));
        chk("no orphan yet", 256'(err_orphan), 256'(0));

        // Fill the tag FIFO with 16 reads and no returns.
        rd_valid = 2'b01;
        repeat (16) @(negedge clk);
        #1;
        chk("full outst", 256'(rd_outstanding), 256'(16));
        chk("full rd_ready", 256'(rd_ready), 256'(2'b00));
        app_rd_valid = 1'b1;
        app_rd_data = D3;
        @(negedge clk);
        app_rd_valid = 1'b0;
        #1;
        chk("free outst", 256'(rd_outstanding), 256'(15));
        chk("free rd_ready", 256'(rd_ready), 256'(2'b01));
        chk("free no cmd", 256'(app_rd_cmd), 256'(0));
        chk("free rsp_valid", 256'(rsp_valid), 256'(2'b01));
        chk("free rsp_data", 256'(rsp_data), 256'(D3));
        @(negedge clk);
        #1;
        chk("refill outst", 256'(rd_outstanding), 256'(16));
        chk("refill rd_ready", 256'(rd_ready), 256'(2'b00));
        chk("refill cmd", 256'(app_rd_cmd), 256'(1));
        rd_valid = 2'b00;

        // Drain down to three outstanding reads.
        app_rd_valid = 1'b1;
        repeat (13) @(negedge clk);
        app_rd_valid = 1'b0;
        @(negedge clk);
        chk("drain outst", 256'(rd_outstanding), 256'(3));

        // Reset mid-flight: outputs return to reset values at once.
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;

        // The three late returns have no tag and are flagged as orphans.
        app_rd_valid = 1'b1;
        app_rd_data = D1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("orphan flag %0d", k), 256'(err_orphan), 256'(1));
            chk($sformatf("orphan rsp %0d", k), 256'(rsp_valid), 256'(2'b00));
            chk($sformatf("orphan outst %0d", k), 256'(rd_outstanding), 256'(0));
        end
        app_rd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("orphan sticky", 256'(err_orphan), 256'(1));
        chk("orphan rsp_data kept", 256'(rsp_data), 256'(0));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/qdr_ui_arbiter.md
# qdr_ui_arbiter

Two-requester arbiter placed between PL client logic and the QDR II+ memory-controller user interface, in the `clk` domain of the QDR example design's user interface. Write and read channels are arbitrated independently, matching the memory's separate D/Q ports. The block gates all traffic on `init_calib_complete`. It tags every issued read so that each returning burst is routed to the requester that issued it.

## Interface
- `ADDR_W`, 19, QDR burst address width (matches `qdriip_sa`).
- `DATA_W`, 144, user data per command (36-bit bus × burst 4).
- `BW_W`, 16, active-low byte-write mask per command.
- `TAG_DEPTH`, 16, max outstanding reads; power of 2, ≥2.

- `clk` in 1: user-interface clock.
- `rst` in 1: asynchronous, active-high reset.
- `init_calib_complete` in 1: controller calibration done.
- `wr_valid` in 2: per-requester write request.
- `wr_addr` in 2×ADDR_W: requester i at [i*ADDR_W +: ADDR_W].
- `wr_data` in 2×DATA_W: write data, same packing.
- `wr_bw_n` in 2×BW_W: byte masks, same packing.
- `wr_ready` out 2: write accepted when valid&ready.
- `rd_valid` in 2: per-requester read request.
- `rd_addr` in 2×ADDR_W: read address.
- `rd_ready` out 2: read accepted when valid&ready.
- `rsp_valid` out 2: one-hot; returned data belongs to requester i.
- `rsp_data` out DATA_W: returned read data.
- `app_wr_cmd` out 1: write command to controller.
- `app_wr_addr` out ADDR_W: controller write address.
- `app_wr_data` out DATA_W: controller write data.
- `app_wr_bw_n` out BW_W: controller write byte masks.
- `app_rd_cmd` out 1: read command to controller.
- `app_rd_addr` out ADDR_W: controller read address.
- `app_rd_valid` in 1: controller read data valid.
- `app_rd_data` in DATA_W: controller read data.
- `rd_outstanding` out $clog2(TAG_DEPTH)+1: reads in flight.
- `err_orphan` out 1: sticky; read data arrived with no tag.

## Operation
- The controller accepts one write and one read command per cycle and applies no backpressure. The arbiter therefore never stalls on the app side.
- **Write channel:** 2-way round-robin.
  - `wr_ready[i]` = `init_calib_complete` & grant[i]; combinational from inputs and priority register.
  - Grant goes to the single valid requester. If both are valid, grant goes to the priority holder.
  - Priority flips to the other requester only after a contested grant.
  - Reset priority: requester 0.
- **Read channel:** identical round-robin with its own priority register. Additionally gated by tag FIFO not full (`rd_outstanding` < TAG_DEPTH).
- **Read accept:** pushes the 1-bit requester ID into the tag FIFO (depth TAG_DEPTH).
- **Read return:** on `app_rd_valid`, the FIFO pops. Next cycle, `rsp_valid[id]`=1 and `rsp_data`=`app_rd_data`. Returns are in order; the controller guarantees in-order return.
- **Orphan data:** `app_rd_valid` with an empty FIFO sets `err_orphan`, which is cleared only by `rst`. The data is dropped and `rsp_valid` stays 0.
- **Full-FIFO push/pop:** a simultaneous pop while full does not allow a push the same cycle. Ready is computed from the registered count; the push occurs the following cycle.
- **Calibration loss:** when `init_calib_complete` is low, all ready signals are 0 and no new commands issue. In-flight reads still return and are routed.
- **Ordering:** no read-after-write hazard checking. Clients own same-address ordering.

## Timing
- Accept in cycle N → `app_*_cmd`, addr, data and mask registered, valid in cycle N+1, pulsed for one cycle per accept.
- Back-to-back accepts yield back-to-back commands. Full throughput is one write and one read per cycle.
- `app_rd_valid` in cycle M → `rsp_valid`/`rsp_data` in cycle M+1.
- `rd_outstanding`: +1 on push, −1 on pop, unchanged on both. It is registered and never exceeds TAG_DEPTH.
- Reset values, all outputs:
  - `app_wr_cmd`=0, `app_rd_cmd`=0.
  - app addr/data=0, `app_wr_bw_n`=all 1s.
  - `rsp_valid`=0, `rsp_data`=0.
  - `rd_outstanding`=0, `err_orphan`=0.
  - Tag FIFO empty; both priorities on requester 0.
- Reset asserted mid-operation: commands in flight are abandoned and the FIFO is flushed. Data returning after reset release is flagged by `err_orphan`.

## Structure
- Shared package `qdr_arb_pkg` holds:
  - default ADDR_W/DATA_W/BW_W;
  - BURST_LEN=4;
  - the requester-ID type (1 bit);
  - the localparam for the all-ones byte mask.
- Sub-module `qdr_rr_arb2`: 2-way round-robin with valid[1:0], enable, grant[1:0], and a priority flop advancing on contested grant. It is instantiated once for writes and once for reads.
- The tag FIFO is inline: pointer-based register array with an occupancy count.

## Test plan
- **Calibration gate:** `init_calib_complete`=0, both `wr_valid`=1 → `wr_ready`=00, no `app_wr_cmd`. Raise calib → `wr_ready`=01 first, `app_wr_cmd` next cycle with requester-0 addr.
- **Contested writes:** both requesters valid for 6 cycles → grants alternate 0,1,0,1,0,1. `app_wr_addr` sequence mirrors that order, one command per cycle.
- **Read routing:** requester 1 reads 0x00010, then requester 0 reads 0x00020; controller returns D1 then D2 → `rsp_valid`=10 with D1, then 01 with D2, each one cycle after `app_rd_valid`.
- **FIFO full:** issue 16 reads with no return → `rd_outstanding`=16 and `rd_ready`=00. One return frees a slot → `rd_ready` reasserts the next cycle, count back to 16 after the new accept.
- **Orphan data:** `app_rd_valid` with an empty FIFO → `err_orphan`=1, sticky; `rsp_valid`=00.
- **Reset mid-flight:** assert `rst` with 3 reads outstanding → all outputs at reset values immediately. After release, the 3 late returns set `err_orphan`.
